// File: rtl/simt_pkg.sv
// Shared types for the SIMT reconvergence controller.
// Stack entries are sized by SIMT_PC_WIDTH / SIMT_SP_PER_MP; the controller's
// PC_WIDTH / SP_PER_MP parameters must match them.
package simt_pkg;

  localparam int SIMT_PC_WIDTH  = 32;
  localparam int SIMT_SP_PER_MP = 8;

  typedef struct packed {
    logic [SIMT_PC_WIDTH-1:0]  rpc;
    logic [SIMT_PC_WIDTH-1:0]  pc;
    logic [SIMT_SP_PER_MP-1:0] mask;
  } stack_entry_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    PUSH_NT = 2'd1,
    POP     = 2'd2,
    HALT    = 2'd3
  } state_t;

  localparam logic [1:0] DIV_SPLIT = 2'b00;
  localparam logic [1:0] DIV_NONE  = 2'b01;
  localparam logic [1:0] DIV_ALL   = 2'b10;
  localparam logic [1:0] DIV_BAD   = 2'b11;

  // The masks decide the class; the evaluator code can be stale because
  // inactive lanes may still vote. Only the illegal code 11 overrides.
  function automatic logic [1:0] classify(input logic [1:0] dv,
                                          input logic nm_zero,
                                          input logic sm_zero);
    if (dv == DIV_BAD) return DIV_NONE;
    if (nm_zero)       return DIV_NONE;
    if (sm_zero)       return DIV_ALL;
    return DIV_SPLIT;
  endfunction

endpackage

// File: rtl/simt_stack_mem.sv
// LIFO reconvergence stack. Top-of-stack is read combinationally; push and
// pop are mutually exclusive, and clear (new warp) wins over both.
module simt_stack_mem
  import simt_pkg::*;
#(
  parameter int STACK_DEPTH = 8,
  parameter int DW          = $clog2(STACK_DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  stack_entry_t  wdata,
  output stack_entry_t  tos,
  output logic [DW-1:0] depth
);

  localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  stack_entry_t mem [STACK_DEPTH];
  logic [AW-1:0] wr_idx, rd_idx;

  assign wr_idx = AW'(depth);
  assign rd_idx = AW'(depth - DW'(1));
  assign tos    = mem[rd_idx];

  // Entry storage; contents are don't-care until pushed, so no reset.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_idx] <= wdata;
  end

  // Occupancy counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       depth <= '0;
    else if (clear) depth <= '0;
    else if (push)  depth <= depth + DW'(1);
    else if (pop)   depth <= depth - DW'(1);
  end

endmodule

// File: rtl/simt_stack_ctrl.sv
// Per-MP SIMT reconvergence controller: owns warp PC / active mask, splits
// divergent branches onto a LIFO stack and pops at the reconvergence PC.
// Optional perf counters (div_count, max_depth) under SIMT_STACK_PERF_EN.
module simt_stack_ctrl
  import simt_pkg::*;
#(
  parameter int SP_PER_MP   = SIMT_SP_PER_MP,
  parameter int PC_WIDTH    = SIMT_PC_WIDTH,
  parameter int STACK_DEPTH = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               warp_start,
  input  logic [PC_WIDTH-1:0]                start_pc,
  input  logic [SP_PER_MP-1:0]               init_mask,
  input  logic                               issue,
  input  logic                               br_valid,
  input  logic [PC_WIDTH-1:0]                br_target,
  input  logic [PC_WIDTH-1:0]                br_reconv,
  input  logic [1:0]                         diverging,
  input  logic [SP_PER_MP-1:0]               next_mask,
  input  logic [SP_PER_MP-1:0]               stack_mask,
  output logic [PC_WIDTH-1:0]                cur_pc,
  output logic [SP_PER_MP-1:0]               cur_mask,
  output logic                               stall,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_depth,
  output logic                               ovf_err
`ifdef SIMT_STACK_PERF_EN
  ,
  output logic [31:0]                        div_count,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   max_depth
`endif
);

  localparam int DW = $clog2(STACK_DEPTH+1);
  // A split needs two free entries.
  localparam logic [DW-1:0] PUSH_LIMIT = DW'(STACK_DEPTH-2);

  state_t               state;
  logic [PC_WIDTH-1:0]  cur_rpc, pc_inc, npc;
  logic [PC_WIDTH-1:0]  lat_target, lat_reconv, lat_pc1;
  logic [SP_PER_MP-1:0] lat_nmask, lat_smask;
  logic [1:0]           br_class;
  logic                 is_split, has_room, reconv_hit;
  logic                 push, pop;
  stack_entry_t         push_entry, tos;

  assign pc_inc     = cur_pc + PC_WIDTH'(1);
  assign br_class   = classify(diverging, next_mask == '0, stack_mask == '0);
  assign is_split   = br_valid && (br_class == DIV_SPLIT);
  assign has_room   = (stack_depth <= PUSH_LIMIT);
  assign npc        = (br_valid && br_class == DIV_ALL) ? br_target : pc_inc;
  assign reconv_hit = (npc == cur_rpc) && (stack_depth != '0);
  assign stall      = (state != RUN);

  // Stack write/pop strobes: E1 (reconvergence continuation) on the branch
  // cycle, E2 (not-taken path) in PUSH_NT, pop in POP. New warp aborts all.
  always_comb begin
    push       = 1'b0;
    pop        = 1'b0;
    push_entry = '0;
    if (!warp_start) begin
      unique case (state)
        RUN: if (is_split && has_room) begin
          push       = 1'b1;
          push_entry = '{rpc: cur_rpc, pc: br_reconv, mask: cur_mask};
        end
        PUSH_NT: begin
          push       = 1'b1;
          push_entry = '{rpc: lat_reconv, pc: lat_pc1, mask: lat_smask};
        end
        POP:     pop = 1'b1;
        default: ;
      endcase
    end
  end

  simt_stack_mem #(.STACK_DEPTH(STACK_DEPTH), .DW(DW)) u_stack (
    .clk   (clk),
    .rst   (rst),
    .clear (warp_start),
    .push  (push),
    .pop   (pop),
    .wdata (push_entry),
    .tos   (tos),
    .depth (stack_depth)
  );

  // Warp context and sequencing FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      cur_pc     <= '0;
      cur_mask   <= '0;
      cur_rpc    <= '1;
      ovf_err    <= 1'b0;
      lat_target <= '0;
      lat_reconv <= '0;
      lat_pc1    <= '0;
      lat_nmask  <= '0;
      lat_smask  <= '0;
    end else if (warp_start) begin
      state    <= RUN;
      cur_pc   <= start_pc;
      cur_mask <= init_mask;
      cur_rpc  <= '1;
      ovf_err  <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (is_split) begin
            if (has_room) begin
              lat_target <= br_target;
              lat_reconv <= br_reconv;
              lat_pc1    <= pc_inc;
              lat_nmask  <= next_mask;
              lat_smask  <= stack_mask;
              state      <= PUSH_NT;
            end else begin
              ovf_err <= 1'b1;
              state   <= HALT;
            end
          end else if (br_valid || issue) begin
            if (reconv_hit) state  <= POP;
            else            cur_pc <= npc;
          end
        end
        PUSH_NT: begin
          cur_pc   <= lat_target;
          cur_mask <= lat_nmask;
          cur_rpc  <= lat_reconv;
          state    <= RUN;
        end
        POP: begin
          // A popped pc equal to its rpc is left alone until the next update.
          cur_pc   <= tos.pc;
          cur_mask <= tos.mask;
          cur_rpc  <= tos.rpc;
          state    <= RUN;
        end
        default: state <= HALT;
      endcase
    end
  end

`ifdef SIMT_STACK_PERF_EN
  // Divergence count (saturating) and stack high-water mark.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_count <= '0;
      max_depth <= '0;
    end else if (warp_start) begin
      div_count <= '0;
      max_depth <= '0;
    end else begin
      if (state == PUSH_NT && div_count != '1) div_count <= div_count + 32'd1;
      if (stack_depth > max_depth)             max_depth <= stack_depth;
    end
  end
`endif

endmodule

// File: tb/tb_simt_stack_ctrl.sv
// Self-checking bench for simt_stack_ctrl (SP_PER_MP=8, STACK_DEPTH=4):
// a vector table applied one cycle per row, expected outputs queued as
// each row is driven and compared after the clock edge.
module tb_simt_stack_ctrl;

  logic        clk, rst;
  logic        warp_start, issue, br_valid;
  logic [31:0] start_pc, br_target, br_reconv;
  logic [7:0]  init_mask, next_mask, stack_mask;
  logic [1:0]  diverging;
  logic [31:0] cur_pc;
  logic [7:0]  cur_mask;
  logic        stall, ovf_err;
  logic [2:0]  stack_depth;
`ifdef SIMT_STACK_PERF_EN
  logic [31:0] div_count;
  logic [2:0]  max_depth;
`endif

  int checks   = 0;
  int failures = 0;

  simt_stack_ctrl #(.SP_PER_MP(8), .PC_WIDTH(32), .STACK_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .warp_start  (warp_start),
    .start_pc    (start_pc),
    .init_mask   (init_mask),
    .issue       (issue),
    .br_valid    (br_valid),
    .br_target   (br_target),
    .br_reconv   (br_reconv),
    .diverging   (diverging),
    .next_mask   (next_mask),
    .stack_mask  (stack_mask),
    .cur_pc      (cur_pc),
    .cur_mask    (cur_mask),
    .stall       (stall),
    .stack_depth (stack_depth),
    .ovf_err     (ovf_err)
`ifdef SIMT_STACK_PERF_EN
    ,
    .div_count   (div_count),
    .max_depth   (max_depth)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ws, spc, imask, iss, brv, tgt, rec, dv, nm, sm;
    logic [31:0] e_pc, e_mask, e_dep, e_stl, e_ovf;
  } vec_t;

  vec_t tv[$];
  vec_t exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    warp_start = 0; issue = 0; br_valid = 0;
    start_pc = 0; init_mask = 0; br_target = 0; br_reconv = 0;
    diverging = 0; next_mask = 0; stack_mask = 0;
  endtask

  // Drive one row for one cycle, then compare the post-edge outputs.
  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    warp_start = v.ws[0];   start_pc   = v.spc;       init_mask  = v.imask[7:0];
    issue      = v.iss[0];  br_valid   = v.brv[0];    br_target  = v.tgt;
    br_reconv  = v.rec;     diverging  = v.dv[1:0];   next_mask  = v.nm[7:0];
    stack_mask = v.sm[7:0];
    exp_q.push_back(v);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    chk({tag, ".pc"},    {32'd0, cur_pc},      {32'd0, e.e_pc});
    chk({tag, ".mask"},  {56'd0, cur_mask},    {56'd0, e.e_mask[7:0]});
    chk({tag, ".depth"}, {61'd0, stack_depth}, {61'd0, e.e_dep[2:0]});
    chk({tag, ".stall"}, {63'd0, stall},       {63'd0, e.e_stl[0]});
    chk({tag, ".ovf"},   {63'd0, ovf_err},     {63'd0, e.e_ovf[0]});
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst.pc",    {32'd0, cur_pc},      64'd0);
    chk("rst.mask",  {56'd0, cur_mask},    64'd0);
    chk("rst.stall", {63'd0, stall},       64'd0);
    chk("rst.depth", {61'd0, stack_depth}, 64'd0);
    chk("rst.ovf",   {63'd0, ovf_err},     64'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    //                 ws spc          imask iss brv tgt     rec     dv nm    sm      pc           mask  dep stl ovf
    // linear code
    tv.push_back(vec_t'{1, 'h10,        'hFF, 0, 0, 0,      0,      0, 0,    0,      'h10,        'hFF, 0, 0, 0});
    tv.push_back(vec_t'{0, 0,           0,    1, 0, 0,      0,      0, 0,    0,      'h11,        'hFF, 0, 0, 0});
    tv.push_back(vec_t'{0, 0,           0,    1, 0, 0,      0,      0, 0,    0,      'h12,        'hFF, 0, 0, 0});
    tv.push_back(vec_t'{0, 0,           0,    1, 0, 0,      0,      0, 0,    0,      'h13,        'hFF, 0, 0, 0});
    // split at 0x20, inputs ignored while stalled
    tv.push_back(vec_t'{1, 'h20,        'hFF, 0, 0, 0,      0,      0, 0,    0,      'h20,        'hFF, 0, 0, 0});
    tv.push_back(vec_t'{0, 0,           0,    0, 1, 'h40,   'h50,   0, 'h0F, 'hF0,   'h20,        'hFF, 1, 1, 0});
    tv.push_back(vec_t'{0, 0,           0,    1, 0, 0,      0,      0, 0,    0,      'h40,        'h0F, 2, 0, 0});
    // all-taken jump to 0x4F, then issue reaches reconv -> POP
    tv.push_back(vec_t'{0, 0,           0,    0, 1, 'h4F,   'h99,   2, 'h0F, 0,      'h4F,        'h0F, 2, 0, 0});
    tv.push_back(vec_t'{0, 0,           0,    1, 0, 0,      0,      0, 0,    0,      'h4F,        'h0F, 2, 1, 0});
    tv.push_back(vec_t'{0, 0,           0,    1, 0, 0,      0,      0, 0,    0,      'h21,        'hF0, 1, 0, 0});
    // none taken, illegal diverging code 11 with split masks -> none taken
    tv.push_back(vec_t'{0, 0,           0,    0, 1, 'h77,   'h88,   1, 0,    'hF0,   'h22,        'hF0, 1, 0, 0});
    tv.push_back(vec_t'{0, 0,           0,    0, 1, 'h77,   'h88,   3, 'h0F, 'hF0,   'h23,        'hF0, 1, 0, 0});
    // branch landing on reconv also pops
    tv.push_back(vec_t'{0, 0,           0,    0, 1, 'h50,   0,      2, 'hF0, 0,      'h23,        'hF0, 1, 1, 0});
    tv.push_back(vec_t'{0, 0,           0,    0, 0, 0,      0,      0, 0,    0,      'h50,        'hFF, 0, 0, 0});
    tv.push_back(vec_t'{0, 0,           0,    1, 0, 0,      0,      0, 0,    0,      'h51,        'hFF, 0, 0, 0});
    // diverging 00 but stack_mask 0 -> all taken, no push
    tv.push_back(vec_t'{0, 0,           0,    0, 1, 'h80,   'h90,   0, 'h0F, 0,      'h80,        'hFF, 0, 0, 0});
    // nested splits until overflow
    tv.push_back(vec_t'{1, 'h100,       'hFF, 0, 0, 0,      0,      0, 0,    0,      'h100,       'hFF, 0, 0, 0});
    tv.push_back(vec_t'{0, 0,           0,    0, 1, 'h200,  'h300,  0, 'h0F, 'hF0,   'h100,       'hFF, 1, 1, 0});
    tv.push_back(vec_t'{0, 0,           0,    0, 0, 0,      0,      0, 0,    0,      'h200,       'h0F, 2, 0, 0});
    tv.push_back(vec_t'{0, 0,           0,    0, 1, 'h210,  'h280,  0, 'h03, 'h0C,   'h200,       'h0F, 3, 1, 0});
    tv.push_back(vec_t'{0, 0,           0,    0, 0, 0,      0,      0, 0,    0,      'h210,       'h03, 4, 0, 0});
    tv.push_back(vec_t'{0, 0,           0,    0, 1, 'h220,  'h230,  0, 'h01, 'h02,   'h210,       'h03, 4, 1, 1});
    tv.push_back(vec_t'{0, 0,           0,    1, 0, 0,      0,      0, 0,    0,      'h210,       'h03, 4, 1, 1});
    tv.push_back(vec_t'{1, 'h10,        'hFF, 0, 0, 0,      0,      0, 0,    0,      'h10,        'hFF, 0, 0, 0});
    // PC wrap
    tv.push_back(vec_t'{1, 'hFFFFFFFE,  'h01, 0, 0, 0,      0,      0, 0,    0,      'hFFFFFFFE,  'h01, 0, 0, 0});
    tv.push_back(vec_t'{0, 0,           0,    1, 0, 0,      0,      0, 0,    0,      'hFFFFFFFF,  'h01, 0, 0, 0});
    tv.push_back(vec_t'{0, 0,           0,    1, 0, 0,      0,      0, 0,    0,      'h0,         'h01, 0, 0, 0});

    idle_inputs();
    rst = 1'b1;
    #12;
    chk("init.pc",    {32'd0, cur_pc},      64'd0);
    chk("init.mask",  {56'd0, cur_mask},    64'd0);
    chk("init.stall", {63'd0, stall},       64'd0);
    chk("init.depth", {61'd0, stack_depth}, 64'd0);
    chk("init.ovf",   {63'd0, ovf_err},     64'd0);
    rst = 1'b0;

    for (int i = 0; i < tv.size(); i++) apply(tv[i], $sformatf("v%0d", i));

    // reset while in PUSH_NT, then a clean split afterwards
    apply(vec_t'{1, 'h20, 'hFF, 0, 0, 0,    0,    0, 0,    0,    'h20, 'hFF, 0, 0, 0}, "r0");
    apply(vec_t'{0, 0,    0,    0, 1, 'h40, 'h50, 0, 'h0F, 'hF0, 'h20, 'hFF, 1, 1, 0}, "r1");
    idle_inputs();
    pulse_reset();
    apply(vec_t'{1, 'h30, 'hAA, 0, 0, 0,    0,    0, 0,    0,    'h30, 'hAA, 0, 0, 0}, "r2");
    apply(vec_t'{0, 0,    0,    0, 1, 'h60, 'h70, 0, 'h0A, 'hA0, 'h30, 'hAA, 1, 1, 0}, "r3");
    apply(vec_t'{0, 0,    0,    0, 0, 0,    0,    0, 0,    0,    'h60, 'h0A, 2, 0, 0}, "r4");
    apply(vec_t'{0, 0,    0,    1, 0, 0,    0,    0, 0,    0,    'h61, 'h0A, 2, 0, 0}, "r5");

`ifdef SIMT_STACK_PERF_EN
    apply(vec_t'{1, 'h0,  'hFF, 0, 0, 0,    0,    0, 0,    0,    'h0,  'hFF, 0, 0, 0}, "p0");
    apply(vec_t'{0, 0,    0,    0, 1, 'h10, 'h20, 0, 'h0F, 'hF0, 'h0,  'hFF, 1, 1, 0}, "p1");
    apply(vec_t'{0, 0,    0,    0, 0, 0,    0,    0, 0,    0,    'h10, 'h0F, 2, 0, 0}, "p2");
    apply(vec_t'{0, 0,    0,    0, 1, 'h14, 'h18, 0, 'h03, 'h0C, 'h10, 'h0F, 3, 1, 0}, "p3");
    apply(vec_t'{0, 0,    0,    0, 0, 0,    0,    0, 0,    0,    'h14, 'h03, 4, 0, 0}, "p4");
    apply(vec_t'{0, 0,    0,    0, 0, 0,    0,    0, 0,    0,    'h14, 'h03, 4, 0, 0}, "p5");
    chk("perf.div_count", {32'd0, div_count}, 64'd2);
    chk("perf.max_depth", {61'd0, max_depth}, 64'd4);
    pulse_reset();
    chk("perf.div_count_rst", {32'd0, div_count}, 64'd0);
    chk("perf.max_depth_rst", {61'd0, max_depth}, 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
